// File: rtl/pkt_ingress_aggregator.sv
// Multi-port 134b packet ingress aggregator.
// Each port owns a packet buffer with a speculative write pointer and a commit pointer, so only
// complete packets become visible to the reader. A packet-atomic round-robin arbiter merges the
// committed packets into one registered output stream with valid/ready backpressure.
module pkt_ingress_aggregator #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      i_pkt_valid,
  input  logic [NUM_PORTS*134-1:0]  i_pkt_data,
  output logic                      o_pkt_valid,
  output logic [133:0]              o_pkt_data,
  output logic [PORT_W-1:0]         o_pkt_port,
  input  logic                      i_ready,
  output logic [NUM_PORTS*16-1:0]   o_drop_cnt,
  output logic [31:0]               o_pkt_cnt
);

  localparam int unsigned WordW = 134;
  localparam int unsigned PtrW  = $clog2(DEPTH);

  typedef logic [PtrW:0]      ptr_t;
  typedef logic [WordW-1:0]   word_t;
  typedef enum logic {StIdle, StSend} state_e;

  word_t                 mem [NUM_PORTS][DEPTH];
  ptr_t                  wr_ptr_q [NUM_PORTS];
  ptr_t                  wr_ptr_d [NUM_PORTS];
  ptr_t                  cm_ptr_q [NUM_PORTS];
  ptr_t                  cm_ptr_d [NUM_PORTS];
  ptr_t                  rd_ptr_q [NUM_PORTS];
  ptr_t                  rd_ptr_d [NUM_PORTS];
  ptr_t                  avail_q  [NUM_PORTS];
  ptr_t                  avail_d  [NUM_PORTS];
  logic [15:0]           drop_cnt_q [NUM_PORTS];
  logic [15:0]           drop_cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]  open_q, open_d;
  logic [NUM_PORTS-1:0]  drop_q, drop_d;
  logic [NUM_PORTS-1:0]  mem_we;
  logic [PtrW-1:0]       mem_addr  [NUM_PORTS];
  word_t                 mem_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]  commit;
  logic [NUM_PORTS-1:0]  pkt_pop;
  logic [NUM_PORTS-1:0]  avail_nz;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  word_t                 out_data_q, out_data_d;
  logic [PORT_W-1:0]     out_port_q, out_port_d;
  logic [PORT_W-1:0]     last_grant_q, last_grant_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  found;
  logic [PORT_W-1:0]     pick;

  // Per-port packet assembly: open, abort, write, drop and commit decisions for the incoming word.
  always_comb begin
    word_t       w;
    logic        in_pkt, abort, full, drop_now, base_drop;
    ptr_t        base, used, nxt;
    logic [1:0]  n_drop;
    logic [16:0] sum;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w             = i_pkt_data[p*WordW +: WordW];
      wr_ptr_d[p]   = wr_ptr_q[p];
      cm_ptr_d[p]   = cm_ptr_q[p];
      open_d[p]     = open_q[p];
      drop_d[p]     = drop_q[p];
      mem_we[p]     = 1'b0;
      mem_wdata[p]  = w;
      commit[p]     = 1'b0;
      in_pkt        = 1'b0;
      abort         = 1'b0;
      base          = wr_ptr_q[p];
      base_drop     = drop_q[p];
      if (i_pkt_valid[p]) begin
        if (w[132]) begin
          // A head always restarts from the commit point, discarding any open packet.
          in_pkt    = 1'b1;
          abort     = open_q[p];
          base      = cm_ptr_q[p];
          base_drop = 1'b0;
        end else begin
          in_pkt    = open_q[p];
        end
      end
      // Occupancy uses the pre-read pointer, so a full buffer drops even if a read happens now.
      used        = base - rd_ptr_q[p];
      full        = (used == ptr_t'(DEPTH));
      drop_now    = base_drop | full;
      nxt         = base + ptr_t'(1);
      mem_addr[p] = base[PtrW-1:0];
      if (in_pkt) begin
        mem_we[p] = ~drop_now;
        if (w[133]) begin
          open_d[p] = 1'b0;
          drop_d[p] = 1'b0;
          if (drop_now) begin
            wr_ptr_d[p] = cm_ptr_q[p];
          end else begin
            wr_ptr_d[p] = nxt;
            cm_ptr_d[p] = nxt;
            commit[p]   = 1'b1;
          end
        end else begin
          open_d[p]   = 1'b1;
          drop_d[p]   = drop_now;
          wr_ptr_d[p] = drop_now ? base : nxt;
        end
      end
      // An abort and a dropped single-word packet can both land in the same cycle.
      n_drop        = {1'b0, abort} + {1'b0, in_pkt & w[133] & drop_now};
      sum           = {1'b0, drop_cnt_q[p]} + 17'(n_drop);
      drop_cnt_d[p] = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  // Committed-packet count per port; commit and tail read in one cycle cancel out.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      avail_d[p]  = avail_q[p] + ptr_t'(commit[p]) - ptr_t'(pkt_pop[p]);
      avail_nz[p] = (avail_q[p] != '0);
    end
  end

  // Round-robin scan starting one past the last granted port.
  always_comb begin
    int unsigned       idx;
    logic [PORT_W-1:0] cand;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = 32'(last_grant_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = PORT_W'(idx);
      if (!found && avail_nz[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Arbiter FSM next state and registered output word selection.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    pkt_pop      = '0;
    for (int p = 0; p < NUM_PORTS; p++) rd_ptr_d[p] = rd_ptr_q[p];
    unique case (state_q)
      StIdle: begin
        if (found) begin
          out_valid_d    = 1'b1;
          out_data_d     = mem[pick][rd_ptr_q[pick][PtrW-1:0]];
          out_port_d     = pick;
          rd_ptr_d[pick] = rd_ptr_q[pick] + ptr_t'(1);
          state_d        = StSend;
        end
      end
      StSend: begin
        if (out_valid_q && i_ready) begin
          if (out_data_q[133]) begin
            pkt_pop[out_port_q] = 1'b1;
            pkt_cnt_d           = pkt_cnt_q + 32'd1;
            last_grant_d        = out_port_q;
            out_valid_d         = 1'b0;
            state_d             = StIdle;
          end else begin
            // The whole packet is committed, so the next word is always present.
            out_data_d           = mem[out_port_q][rd_ptr_q[out_port_q][PtrW-1:0]];
            rd_ptr_d[out_port_q] = rd_ptr_q[out_port_q] + ptr_t'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p]   <= '0;
        cm_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        avail_q[p]    <= '0;
        drop_cnt_q[p] <= '0;
      end
      open_q       <= '0;
      drop_q       <= '0;
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= '0;
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
      pkt_cnt_q    <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p]   <= wr_ptr_d[p];
        cm_ptr_q[p]   <= cm_ptr_d[p];
        rd_ptr_q[p]   <= rd_ptr_d[p];
        avail_q[p]    <= avail_d[p];
        drop_cnt_q[p] <= drop_cnt_d[p];
      end
      open_q       <= open_d;
      drop_q       <= drop_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
      last_grant_q <= last_grant_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  // Buffer storage; contents need no reset because the pointers gate what is visible.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (mem_we[p]) mem[p][mem_addr[p]] <= mem_wdata[p];
    end
  end

  // Output mapping.
  always_comb begin
    o_pkt_valid = out_valid_q;
    o_pkt_data  = out_data_q;
    o_pkt_port  = out_port_q;
    o_pkt_cnt   = pkt_cnt_q;
    for (int p = 0; p < NUM_PORTS; p++) o_drop_cnt[p*16 +: 16] = drop_cnt_q[p];
  end

endmodule

// File: tb/tb_pkt_ingress_aggregator.sv
// Scoreboard bench for pkt_ingress_aggregator: stimulus feeds a packet-level reference model that
// queues expected words per port; an independent monitor pops and compares on every transfer.
module tb_pkt_ingress_aggregator;
  localparam int NP    = 4;
  localparam int DEPTH = 64;
  localparam int PW    = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NP-1:0]       i_pkt_valid = '0;
  logic [NP*134-1:0]   i_pkt_data = '0;
  logic                o_pkt_valid;
  logic [133:0]        o_pkt_data;
  logic [PW-1:0]       o_pkt_port;
  logic                i_ready = 1'b1;
  logic [NP*16-1:0]    o_drop_cnt;
  logic [31:0]         o_pkt_cnt;

  pkt_ingress_aggregator #(.NUM_PORTS(NP), .DEPTH(DEPTH), .PORT_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pkt_valid (i_pkt_valid),
    .i_pkt_data  (i_pkt_data),
    .o_pkt_valid (o_pkt_valid),
    .o_pkt_data  (o_pkt_data),
    .o_pkt_port  (o_pkt_port),
    .i_ready     (i_ready),
    .o_drop_cnt  (o_drop_cnt),
    .o_pkt_cnt   (o_pkt_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-port per-cycle input schedule.
  logic [133:0] sched_w [NP][$];
  bit           sched_v [NP][$];
  // Reference model state.
  logic [133:0] exp_q   [NP][$];
  logic [133:0] cur_pkt [NP][$];
  bit           m_open  [NP];
  int           m_drop  [NP];
  int           m_pkts;
  // Monitor logs.
  int head_log[$];
  int tail_log[$];
  int port_log[$];
  int valid_seen;
  int ready_mode = 0;
  int tail_drv_cyc [NP];

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [133:0] mk(input bit h, input bit t);
    logic [127:0] d;
    logic [3:0]   nb;
    d  = {$urandom(), $urandom(), $urandom(), $urandom()};
    nb = t ? 4'($urandom_range(15, 0)) : 4'd0;
    return {t, h, nb, d};
  endfunction

  // Packet-level model: heads restart, tails commit unless the packet outgrew the buffer.
  task automatic model_in(input int p, input logic [133:0] w);
    if (w[132]) begin
      if (m_open[p]) m_drop[p]++;
      cur_pkt[p].delete();
      m_open[p] = 1'b1;
    end else if (!m_open[p]) begin
      return;
    end
    cur_pkt[p].push_back(w);
    if (w[133]) begin
      m_open[p] = 1'b0;
      if (cur_pkt[p].size() <= DEPTH) begin
        for (int i = 0; i < cur_pkt[p].size(); i++) exp_q[p].push_back(cur_pkt[p][i]);
        m_pkts++;
      end else begin
        m_drop[p]++;
      end
      cur_pkt[p].delete();
    end
  endtask

  task automatic push_word(input int p, input bit v, input logic [133:0] w);
    sched_v[p].push_back(v);
    sched_w[p].push_back(w);
    if (v) model_in(p, w);
  endtask

  task automatic push_idle(input int p, input int n);
    for (int i = 0; i < n; i++) push_word(p, 1'b0, '0);
  endtask

  task automatic push_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) push_word(p, 1'b1, mk(i == 0, i == len - 1));
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      cur_pkt[p].delete();
      m_open[p] = 1'b0;
      m_drop[p] = 0;
    end
    m_pkts = 0;
    head_log.delete();
    tail_log.delete();
    port_log.delete();
    valid_seen = 0;
  endtask

  function automatic bit idle_all();
    for (int p = 0; p < NP; p++)
      if (sched_v[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
    return !o_pkt_valid;
  endfunction

  task automatic do_reset();
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (!idle_all() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    tests++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL drain_timeout: waited %0d cycles, want under 5000", n);
    end
  endtask

  task automatic check_counters(input string name);
    check({name, "_pkt_cnt"}, o_pkt_cnt, m_pkts);
    for (int p = 0; p < NP; p++) check({name, "_drop_cnt"}, o_drop_cnt[p*16 +: 16], m_drop[p]);
  endtask

  // Input driver: one scheduled entry per port per cycle; reset discards pending input.
  initial forever begin
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        sched_v[p].delete();
        sched_w[p].delete();
        i_pkt_valid[p] = 1'b0;
      end else if (sched_v[p].size() > 0) begin
        i_pkt_valid[p]             = sched_v[p].pop_front();
        i_pkt_data[p*134 +: 134]   = sched_w[p].pop_front();
        if (i_pkt_valid[p] && i_pkt_data[p*134 + 133]) tail_drv_cyc[p] = cyc;
      end else begin
        i_pkt_valid[p] = 1'b0;
      end
    end
  end

  // Sink ready driver: 0 = always ready, 1 = toggle, 2 = random.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ~i_ready;
      default: i_ready = ($urandom_range(9, 0) < 7);
    endcase
  end

  // Monitor: checks every transferred word against the per-port expected queue.
  bit           in_pkt_m = 1'b0;
  bit           prev_stall = 1'b0;
  logic [133:0] prev_data;
  logic [PW-1:0] prev_port;
  logic [PW-1:0] cur_port;
  always @(negedge clk) begin
    if (rst) begin
      in_pkt_m   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (o_pkt_valid) valid_seen++;
      if (prev_stall) begin
        check("hold_valid", o_pkt_valid, 1'b1);
        check("hold_data", o_pkt_data, prev_data);
        check("hold_port", o_pkt_port, prev_port);
      end
      if (o_pkt_valid && i_ready) begin
        if (!in_pkt_m) begin
          cur_port = o_pkt_port;
          head_log.push_back(cyc);
          port_log.push_back(int'(cur_port));
          in_pkt_m = 1'b1;
        end else begin
          check("port_stable", o_pkt_port, cur_port);
        end
        if (exp_q[cur_port].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: port %0d got %0h, want no word", cur_port, o_pkt_data);
        end else begin
          check("word", o_pkt_data, exp_q[cur_port].pop_front());
        end
        if (o_pkt_data[133]) begin
          in_pkt_m = 1'b0;
          tail_log.push_back(cyc);
        end
      end
      prev_stall = o_pkt_valid && !i_ready;
      prev_data  = o_pkt_data;
      prev_port  = o_pkt_port;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int budget;
    int len;
    int gap;
    int ab;

    // Reset state.
    do_reset();
    check("rst_valid", o_pkt_valid, 1'b0);
    check("rst_data", o_pkt_data, '0);
    check("rst_port", o_pkt_port, '0);
    check("rst_drop", o_drop_cnt, '0);
    check("rst_pkt_cnt", o_pkt_cnt, '0);

    // Single 4-word packet on port 0.
    do_reset();
    ready_mode = 0;
    push_pkt(0, 4);
    drain();
    check("t1_npkts", head_log.size(), 1);
    if (head_log.size() == 1) begin
      check("t1_latency", head_log[0] - tail_drv_cyc[0], 2);
      check("t1_port", port_log[0], 0);
    end
    check("t1_pkt_cnt", o_pkt_cnt, 1);

    // Three ports commit together: round-robin order with one idle cycle between packets.
    do_reset();
    push_pkt(0, 3);
    push_pkt(1, 3);
    push_pkt(2, 3);
    drain();
    check("t2_npkts", port_log.size(), 3);
    if (port_log.size() == 3 && tail_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t2_order", port_log[i], i);
        check("t2_contig", tail_log[i] - head_log[i], 2);
        if (i > 0) check("t2_gap", head_log[i] - tail_log[i-1], 2);
      end
    end
    check("t2_pkt_cnt", o_pkt_cnt, 3);

    // Oversized packet is dropped whole; the following packet survives.
    do_reset();
    push_pkt(1, 70);
    push_pkt(1, 2);
    drain();
    check("t3_drop1", o_drop_cnt[31:16], 1);
    check("t3_pkt_cnt", o_pkt_cnt, 1);
    check("t3_npkts", port_log.size(), 1);

    // Orphan body ignored, head-before-tail aborts the open packet.
    do_reset();
    push_word(2, 1'b1, mk(0, 0));
    push_word(2, 1'b1, mk(1, 0));
    push_word(2, 1'b1, mk(0, 0));
    push_word(2, 1'b1, mk(1, 0));
    push_word(2, 1'b1, mk(0, 0));
    push_word(2, 1'b1, mk(0, 1));
    drain();
    check("t4_drop2", o_drop_cnt[47:32], 1);
    check("t4_pkt_cnt", o_pkt_cnt, 1);

    // Toggling ready during a 5-word packet.
    do_reset();
    ready_mode = 1;
    push_pkt(3, 5);
    drain();
    ready_mode = 0;
    check("t5_pkt_cnt", o_pkt_cnt, 1);
    check("t5_port", port_log.size() == 1 ? port_log[0] : -1, 3);

    // Randomised rounds: gaps, aborts, orphans and random backpressure on all ports.
    do_reset();
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NP; p++) begin
        budget = 0;
        forever begin
          len = $urandom_range(8, 1);
          gap = $urandom_range(3, 0);
          ab  = ($urandom_range(7, 0) == 0) ? $urandom_range(3, 1) : 0;
          if (budget + len + ab > 56) break;
          push_idle(p, gap);
          for (int i = 0; i < ab; i++) push_word(p, 1'b1, mk(i == 0, 1'b0));
          push_pkt(p, len);
          if ($urandom_range(9, 0) == 0) push_word(p, 1'b1, mk(0, 1'($urandom_range(1, 0))));
          budget += len + ab;
        end
      end
      drain();
      check_counters("rand");
    end
    ready_mode = 0;

    // Guarantee nonzero counters, then reset in the middle of a packet.
    push_word(1, 1'b1, mk(1, 0));
    push_pkt(1, 2);
    drain();
    check_counters("t6_pre");
    push_pkt(0, 10);
    push_pkt(3, 10);
    push_pkt(0, 4);
    n = 0;
    while (!o_pkt_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_send_started", o_pkt_valid, 1'b1);
    do_reset();
    check("t6_valid", o_pkt_valid, 1'b0);
    check("t6_data", o_pkt_data, '0);
    check("t6_pkt_cnt", o_pkt_cnt, '0);
    check("t6_drop", o_drop_cnt, '0);
    repeat (100) @(negedge clk);
    check("t6_no_output", valid_seen, 0);
    check("t6_pkt_cnt_after", o_pkt_cnt, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_ingress_aggregator.md
# pkt_ingress_aggregator

Parametrised multi-port ingress stage that merges NUM_PORTS independent 134b packet streams, one per RGMII port's gmii-to-134b converter, into a single 134b stream toward the UM. Each port has a DEPTH-word packet buffer with commit/rewind semantics, so only complete packets are forwarded and overflowing packets are dropped whole. Output is packet-atomic round-robin with per-word valid/ready backpressure, a port-ID sideband and per-port drop counters.

## Interface
- NUM_PORTS, 4, number of ingress ports (2..8)
- DEPTH, 64, words per port buffer; power of two, ≥4
- PORT_W, $clog2(NUM_PORTS), port-ID width (derived)
- clk  in  1  single clock for all logic
- rst  in  1  reset; synchronous, active-high
- i_pkt_valid  in  NUM_PORTS  per-port word strobe; no backpressure to sources
- i_pkt_data  in  NUM_PORTS*134  port p at [p*134 +: 134]; [133]=tail, [132]=head, [131:128] valid bytes, [127:0] data
- o_pkt_valid  out  1  output word valid
- o_pkt_data  out  134  output word, format unchanged
- o_pkt_port  out  PORT_W  ingress port of current output packet
- i_ready  in  1  sink accepts word when high with o_pkt_valid
- o_drop_cnt  out  NUM_PORTS*16  per-port dropped-packet counters, saturating
- o_pkt_cnt  out  32  total packets forwarded (tail transfers), wrapping

## Operation
- Per-port write side (independent per port), pointers PTR_W+1 bits: wr_ptr (speculative), cm_ptr (commit), rd_ptr; used = wr_ptr − rd_ptr.
- Word with head=1: opens packet; if one already open, that packet is aborted (wr_ptr←cm_ptr, drop_cnt+1) and the new one starts from cm_ptr.
- Word without head while no packet open: ignored, not counted.
- Word in open packet: written at wr_ptr if used<DEPTH and not dropping; else sets drop flag, no write.
- Word with tail=1 (head+tail = single-word packet): closes packet. No drop flag → cm_ptr←wr_ptr after write, pkt_avail+1. Drop flag → wr_ptr←cm_ptr, drop_cnt+1, flag cleared.
- Packets longer than DEPTH are always dropped.
- Reader sees only words below cm_ptr; pkt_avail = committed packets not yet fully read.
- Arbiter FSM: IDLE → scan ports starting at last_grant+1 (mod NUM_PORTS); first with pkt_avail>0 becomes grant, → SEND. SEND: present words of granted port; on transfer of tail word, pkt_avail−1, o_pkt_cnt+1, last_grant←grant → IDLE. No other port is interleaved mid-packet.
- o_pkt_port = grant, stable for whole packet.
- drop_cnt saturates at 0xFFFF; o_pkt_cnt wraps at 2^32.

## Timing
- Reset: all pointers, pkt_avail, drop flags, open flags = 0; FSM IDLE; last_grant = NUM_PORTS−1 (port 0 first); o_pkt_valid=0, o_pkt_data=0, o_pkt_port=0, o_drop_cnt=0, o_pkt_cnt=0; outputs show these one cycle after rst sampled high.
- Reset mid-packet: buffered and in-flight packets discarded; o_pkt_valid low from next cycle.
- Input accepted every cycle per port; no input-side stall.
- Commit: tail sampled cycle T → visible to arbiter in T+1; arbitration in T+1; o_pkt_valid=1 with head word at T+2 when FSM IDLE and no other eligible port ahead.
- o_pkt_valid, o_pkt_data, o_pkt_port registered; while o_pkt_valid && !i_ready they hold.
- Sustained SEND throughput 1 word/cycle with i_ready=1; one idle cycle between packets (IDLE arbitration).
- Same-cycle tail commit and tail read on one port: pkt_avail unchanged net.
- Same-cycle write and read on full buffer: used evaluated before read (word dropped).
- Pointer wrap-around via MSB; full = used==DEPTH, empty = rd_ptr==cm_ptr.

## Test plan
- Port 0 sends 4-word packet (head, 2 body, tail), i_ready=1 → same 4 words on output, o_pkt_port=0, head at tail-cycle+2, o_pkt_cnt=1.
- Ports 0,1,2 each commit a 3-word packet same cycle → output order 0,1,2, each 3 contiguous words, one idle cycle between, o_pkt_cnt=3.
- DEPTH=64, port 1 sends 70-word packet then 2-word packet → first dropped, o_drop_cnt[1]=1, only 2-word packet output.
- Port 2 head, 2 words, new head before tail, then tail → aborted packet counted (drop_cnt[2]=1), second packet forwarded intact.
- Toggle i_ready 1/0 every cycle during a 5-word packet → o_pkt_data held during stalls, 5 words delivered in order with no duplication.
- Assert rst for 1 cycle mid-SEND with packets buffered on ports 0 and 3 → o_pkt_valid=0 next cycle, all counters 0, nothing from old packets forwarded afterward.
